// File: rtl/jellyvl_synctimer_timer.sv
// rtl/jellyvl_synctimer_timer.sv - fractional-step synchronised timer with rate-limited +/-1 adjust
module jellyvl_synctimer_timer #(
  parameter int TIMER_WIDTH     = 64,
  parameter int NUMERATOR       = 10,
  parameter int DENOMINATOR     = 3,
  parameter int ADJUST_INTERVAL = 1,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  input  logic                   status_clear,
  output logic [COUNT_WIDTH-1:0] status_adjust_plus,
  output logic [COUNT_WIDTH-1:0] status_adjust_minus,
  output logic [TIMER_WIDTH-1:0] current_time
);

  localparam int STEP_INT = NUMERATOR / DENOMINATOR;
  localparam int STEP_REM = NUMERATOR % DENOMINATOR;
  // frac + REM can reach 2*DENOMINATOR-2, so size for that sum
  localparam int FW = $clog2(2 * DENOMINATOR + 1);
  localparam int IW = (ADJUST_INTERVAL > 1) ? $clog2(ADJUST_INTERVAL) : 1;

  if (DENOMINATOR < 1 || ADJUST_INTERVAL < 1 || STEP_INT < 1) begin : g_param_check
    $error("jellyvl_synctimer_timer: invalid NUMERATOR/DENOMINATOR/ADJUST_INTERVAL");
  end

  logic [FW-1:0]          frac, frac_sum, frac_next;
  logic                   carry;
  logic                   accept;
  logic [TIMER_WIDTH-1:0] adj;
  logic [TIMER_WIDTH-1:0] time_next;
  logic [IW-1:0]          ivl, ivl_next;
  logic                   count_en;

  always_comb begin
    frac_sum  = frac + FW'(STEP_REM);
    carry     = (frac_sum >= FW'(DENOMINATOR));
    frac_next = carry ? (frac_sum - FW'(DENOMINATOR)) : frac_sum;
    accept    = adjust_valid && adjust_ready;
    adj       = '0;
    if (accept) begin
      adj = adjust_sign ? '1 : TIMER_WIDTH'(1);
    end
    time_next = current_time + TIMER_WIDTH'(STEP_INT) + TIMER_WIDTH'(carry) + adj;
    ivl_next  = '0;
    if (accept) begin
      ivl_next = IW'(ADJUST_INTERVAL - 1);
    end else if (ivl != '0) begin
      ivl_next = ivl - IW'(1);
    end
    // a beat swallowed by a coarse set is not counted
    count_en = accept && !set_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_time <= '0;
      frac         <= '0;
      ivl          <= '0;
      adjust_ready <= 1'b0;
    end else begin
      ivl          <= ivl_next;
      adjust_ready <= (ivl_next == '0);
      if (set_valid) begin
        current_time <= set_time;
        frac         <= '0;
      end else begin
        current_time <= time_next;
        frac         <= frac_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_adjust_plus  <= '0;
      status_adjust_minus <= '0;
    end else if (status_clear) begin
      status_adjust_plus  <= '0;
      status_adjust_minus <= '0;
    end else if (count_en) begin
      if (!adjust_sign && status_adjust_plus != '1) begin
        status_adjust_plus <= status_adjust_plus + COUNT_WIDTH'(1);
      end
      if (adjust_sign && status_adjust_minus != '1) begin
        status_adjust_minus <= status_adjust_minus + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// tb/tb_jellyvl_synctimer_timer.sv - directed self-checking bench for jellyvl_synctimer_timer
module tb_jellyvl_synctimer_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] set_time = '0;
  logic        set_valid = 1'b0;
  logic        adjust_sign = 1'b0;
  logic        adjust_valid = 1'b0;
  logic        status_clear = 1'b0;

  logic        rdy_a, rdy_b, rdy_c;
  logic [15:0] plus_a, minus_a, plus_b, minus_b;
  logic [1:0]  plus_c, minus_c;
  logic [63:0] time_a, time_b, time_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jellyvl_synctimer_timer u_dut_a (
    .rst(rst), .clk(clk), .set_time(set_time), .set_valid(set_valid),
    .adjust_sign(adjust_sign), .adjust_valid(adjust_valid), .adjust_ready(rdy_a),
    .status_clear(status_clear), .status_adjust_plus(plus_a),
    .status_adjust_minus(minus_a), .current_time(time_a)
  );

  jellyvl_synctimer_timer #(.ADJUST_INTERVAL(4)) u_dut_b (
    .rst(rst), .clk(clk), .set_time(set_time), .set_valid(set_valid),
    .adjust_sign(adjust_sign), .adjust_valid(adjust_valid), .adjust_ready(rdy_b),
    .status_clear(status_clear), .status_adjust_plus(plus_b),
    .status_adjust_minus(minus_b), .current_time(time_b)
  );

  jellyvl_synctimer_timer #(.ADJUST_INTERVAL(8), .COUNT_WIDTH(2)) u_dut_c (
    .rst(rst), .clk(clk), .set_time(set_time), .set_valid(set_valid),
    .adjust_sign(adjust_sign), .adjust_valid(adjust_valid), .adjust_ready(rdy_c),
    .status_clear(status_clear), .status_adjust_plus(plus_c),
    .status_adjust_minus(minus_c), .current_time(time_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_valid = 1'b0; adjust_valid = 1'b0; adjust_sign = 1'b0; status_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic sel_ready(input int inst);
    case (inst)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  // waits (bounded) for the chosen instance to be ready, then presents one beat
  task automatic adj_beat(input int inst, input logic sign, input logic clr);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel_ready(inst)) break;
    end
    check("rdy_wait", {63'd0, sel_ready(inst)}, 64'd1);
    adjust_valid = 1'b1; adjust_sign = sign; status_clear = clr;
    @(posedge clk);
    #1;
    adjust_valid = 1'b0; adjust_sign = 1'b0; status_clear = 1'b0;
  endtask

  initial begin
    int highs;

    // reset state and plain fractional stepping 3,3,4
    do_reset();
    check("rst_time", time_a, 64'd0);
    check("rst_ready", {63'd0, rdy_a}, 64'd0);
    check("rst_plus", {48'd0, plus_a}, 64'd0);
    check("rst_minus", {48'd0, minus_a}, 64'd0);
    tick(1); check("step1", time_a, 64'd3); check("ready_up", {63'd0, rdy_a}, 64'd1);
    tick(1); check("step2", time_a, 64'd6);
    tick(1); check("step3", time_a, 64'd10);
    tick(27); check("step30", time_a, 64'd100);

    // one +1 beat with frac at 0: +4, then +3, +4
    adj_beat(0, 1'b0, 1'b0);
    check("plus_t0", time_a, 64'd104);
    tick(1); check("plus_t1", time_a, 64'd107);
    tick(1); check("plus_t2", time_a, 64'd111);
    check("plus_cnt", {48'd0, plus_a}, 64'd1);

    // set with a coincident beat: loaded, beat dropped, frac cleared, wraps
    @(negedge clk);
    set_time = 64'hFFFF_FFFF_FFFF_FFFE; set_valid = 1'b1;
    adjust_valid = 1'b1; adjust_sign = 1'b0;
    @(posedge clk); #1;
    set_valid = 1'b0; adjust_valid = 1'b0;
    check("set_time", time_a, 64'hFFFF_FFFF_FFFF_FFFE);
    check("set_uncounted", {48'd0, plus_a}, 64'd1);
    tick(1); check("wrap", time_a, 64'd1);
    tick(1); check("wrap_s2", time_a, 64'd4);
    tick(1); check("wrap_s3", time_a, 64'd8);

    // interval 4, valid held with sign 1
    do_reset();
    tick(1);
    check("b_ready1", {63'd0, rdy_b}, 64'd1);
    adjust_valid = 1'b1; adjust_sign = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rdy_b) highs++;
    end
    adjust_valid = 1'b0; adjust_sign = 1'b0;
    check("b_highs", 64'(highs), 64'd10);
    check("b_minus", {48'd0, minus_b}, 64'd10);
    check("b_time", time_b, 64'd126);

    // 2-bit counters saturate; clear beats a coincident accept
    do_reset();
    for (int i = 0; i < 5; i++) adj_beat(2, 1'b0, 1'b0);
    check("c_sat", {62'd0, plus_c}, 64'd3);
    check("c_minus0", {62'd0, minus_c}, 64'd0);
    adj_beat(2, 1'b1, 1'b1);
    check("c_clr_plus", {62'd0, plus_c}, 64'd0);
    check("c_clr_minus", {62'd0, minus_c}, 64'd0);

    // async reset mid-interval
    adj_beat(2, 1'b0, 1'b0);
    tick(2);
    check("c_busy", {63'd0, rdy_c}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_time", time_c, 64'd0);
    check("async_ready", {63'd0, rdy_c}, 64'd0);
    check("async_plus", {62'd0, plus_c}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rel_ready0", {63'd0, rdy_c}, 64'd0);
    tick(1);
    check("rel_ready1", {63'd0, rdy_c}, 64'd1);
    check("rel_time", time_c, 64'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
